vga_port_arb: RTL and testbench
===============================

VGA_PORT_ARB -- requirements
Module: vga_port_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum cycles to wait for i_vga_ready_h after a strobe; legal range 4..255.
REQ-002 i_clk  input  1  sole clock; all logic on posedge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_a_cmd / i_b_cmd  input  8  requester A/B VGA command.
REQ-005 i_a_cur_adr / i_b_cur_adr  input  11  requester A/B cursor address.
REQ-006 i_a_port / i_b_port  input  8  requester A/B write data.
REQ-007 i_a_rl_wh / i_b_rl_wh  input  1  requester A/B direction; 0=read, 1=write.
REQ-008 i_a_cs_h / i_b_cs_h  input  1  requester A/B one-cycle request strobe; cmd/adr/port/rl_wh valid in that cycle.
REQ-009 o_a_ready_h / o_b_ready_h  output  1  high = requester slot empty, strobe accepted.
REQ-010 o_a_port / o_b_port  output  8  read data returned to A/B; held until that requester's next completion.
REQ-011 o_a_done / o_b_done  output  1  one-cycle completion pulse to A/B.
REQ-012 o_vga_cmd  output  8;  o_vga_cur_adr  output  11;  o_vga_port  output  8  shared VGA register port.
REQ-013 o_vga_cs_h  output  1;  o_vga_rl_wh  output  1  VGA strobe and direction.
REQ-014 i_vga_ready_h  input  1;  i_vga_port  input  8  VGA ready and read data.
REQ-015 o_timeout  output  1  sticky flag: a transaction timed out; cleared only by reset.

Function
REQ-016 Each requester SHALL own a one-deep slot; an i_x_cs_h strobe while o_x_ready_h=1 SHALL latch cmd, cur_adr, port and rl_wh and set the slot pending.
REQ-017 A strobe while o_x_ready_h=0 SHALL be dropped and SHALL NOT alter the slot.
REQ-018 o_x_ready_h SHALL be low from the cycle after an accepted strobe until the cycle after o_x_done pulses.
REQ-019 FSM states SHALL be: IDLE, ISSUE, HOLD, WAIT_RDY, DONE.
REQ-020 IDLE: if any slot is pending, grant round-robin; the requester not granted last SHALL win a tie, and the pointer SHALL reset to favour A; then go to ISSUE.
REQ-021 ISSUE: drive the granted slot's fields onto o_vga_cmd/cur_adr/port/rl_wh; assert o_vga_cs_h for exactly one cycle; go to HOLD.
REQ-022 HOLD: deassert o_vga_cs_h; keep o_vga_rl_wh; wait exactly one cycle; go to WAIT_RDY.
REQ-023 WAIT_RDY: on i_vga_ready_h=1, capture i_vga_port into o_x_port if rl_wh=0 (write leaves o_x_port unchanged), then go to DONE.
REQ-024 WAIT_RDY timeout: after TIMEOUT_CYC cycles with ready low, set o_timeout, force o_x_port=8'hFF on a read, and go to DONE.
REQ-025 DONE: pulse o_x_done for the granted requester, clear its slot, update the round-robin pointer, return to IDLE.
REQ-026 Latency from an accepted strobe on an idle arbiter with ready already high: o_vga_cs_h 2 cycles later; o_x_done 5 cycles later.
REQ-027 o_vga_cmd/cur_adr/port/rl_wh SHALL hold their last driven values outside ISSUE..DONE.
REQ-028 A new strobe to the granted requester in its DONE cycle SHALL be dropped, because ready is still low.
REQ-029 A strobe from the non-granted requester during any state SHALL be latched if its slot is empty.
REQ-030 Simultaneous A and B strobes SHALL both latch; service order follows the round-robin pointer.
REQ-031 The timeout counter SHALL be 8 bits, cleared on entry to WAIT_RDY, and SHALL saturate without wrapping.

Reset
REQ-032 Reset assertion SHALL asynchronously force IDLE and the round-robin pointer to A.
REQ-033 Reset SHALL clear both slots and the timeout counter.
REQ-034 Reset SHALL set all outputs to 0, except o_a_ready_h=o_b_ready_h=1.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no done pulse.
REQ-036 Reset deassertion SHALL take effect at the first clock edge after release.

Structure
REQ-037 The FSM state encoding and the VGA command constants (8'h00, 8'h02, 8'h03, 8'h04, 8'h80, 8'h81, 8'h82, 8'h84, 8'h85) SHALL live in a shared package, vga_pkg.
REQ-038 The per-requester slot SHALL be a sub-module, vga_req_slot, instantiated twice.

Verification
REQ-039 A write: A strobe cmd=8'h81, port=8'h41, rl_wh=1 with ready high -> o_vga_cs_h 2 cycles later with o_vga_port=8'h41; o_a_done 5 cycles after the strobe.
REQ-040 A read: A strobe cmd=8'h00, rl_wh=0; VGA drives i_vga_port=8'h5A with ready high -> o_a_port=8'h5A on o_a_done.
REQ-041 Simultaneous strobes: A and B strobe in the same cycle after reset -> A issued first, then B; repeat -> B first.
REQ-042 Timeout: read strobe with i_vga_ready_h held low -> o_a_done after TIMEOUT_CYC+4 cycles, o_a_port=8'hFF, o_timeout=1 and staying 1.
REQ-043 Busy drop: second A strobe while o_a_ready_h=0 -> ignored; exactly one VGA transaction is issued.
REQ-044 Reset mid-transaction: assert i_rst_n=0 in WAIT_RDY -> all outputs at reset values, no done pulse, next strobe served normally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA register-port arbiter: FSM states,
// VGA command codes and the request record carried by each slot.
package vga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_HOLD     = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_DONE     = 3'd4
  } vga_state_t;

  localparam logic [7:0] VGA_CMD_H00 = 8'h00;
  localparam logic [7:0] VGA_CMD_H02 = 8'h02;
  localparam logic [7:0] VGA_CMD_H03 = 8'h03;
  localparam logic [7:0] VGA_CMD_H04 = 8'h04;
  localparam logic [7:0] VGA_CMD_H80 = 8'h80;
  localparam logic [7:0] VGA_CMD_H81 = 8'h81;
  localparam logic [7:0] VGA_CMD_H82 = 8'h82;
  localparam logic [7:0] VGA_CMD_H84 = 8'h84;
  localparam logic [7:0] VGA_CMD_H85 = 8'h85;

  // Read data returned to a requester whose transaction timed out.
  localparam logic [7:0] VGA_TIMEOUT_DATA = 8'hFF;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [10:0] cur_adr;
    logic [7:0]  port;
    logic        rl_wh;
  } vga_req_t;

  // Round-robin pick: B wins if it alone is pending, or on a tie when B holds priority.
  function automatic logic pick_b(input logic a_pend, input logic b_pend, input logic prio_b);
    return b_pend && (!a_pend || prio_b);
  endfunction

endpackage

// File: rtl/vga_req_slot.sv
// One-deep request slot for a single requester; also holds the read data
// returned on that requester's last completion.
module vga_req_slot
  import vga_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cs_h,
  input  vga_req_t   i_req,
  input  logic       i_clr,
  input  logic       i_rd_load,
  input  logic [7:0] i_rd_data,
  output logic       o_ready_h,
  output vga_req_t   o_req,
  output logic [7:0] o_rd_data
);

  logic       r_pend;
  vga_req_t   r_req;
  logic [7:0] r_rd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= 1'b0;
      r_req  <= '0;
      r_rd   <= '0;
    end else begin
      if (i_clr) begin
        r_pend <= 1'b0;
      end else if (i_cs_h && !r_pend) begin
        r_pend <= 1'b1;
        r_req  <= i_req;
      end
      if (i_rd_load) begin
        r_rd <= i_rd_data;
      end
    end
  end

  assign o_ready_h = !r_pend;
  assign o_req     = r_req;
  assign o_rd_data = r_rd;

endmodule

// File: rtl/vga_port_arb.sv
// Two-requester round-robin arbiter onto a shared VGA register port, with
// a one-deep slot per requester and a ready timeout that returns 8'hFF.
module vga_port_arb
  import vga_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_a_cmd,
  input  logic [10:0] i_a_cur_adr,
  input  logic [7:0]  i_a_port,
  input  logic        i_a_rl_wh,
  input  logic        i_a_cs_h,
  input  logic [7:0]  i_b_cmd,
  input  logic [10:0] i_b_cur_adr,
  input  logic [7:0]  i_b_port,
  input  logic        i_b_rl_wh,
  input  logic        i_b_cs_h,
  output logic        o_a_ready_h,
  output logic        o_b_ready_h,
  output logic [7:0]  o_a_port,
  output logic [7:0]  o_b_port,
  output logic        o_a_done,
  output logic        o_b_done,
  output logic [7:0]  o_vga_cmd,
  output logic [10:0] o_vga_cur_adr,
  output logic [7:0]  o_vga_port,
  output logic        o_vga_cs_h,
  output logic        o_vga_rl_wh,
  input  logic        i_vga_ready_h,
  input  logic [7:0]  i_vga_port,
  output logic        o_timeout
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  vga_state_t  r_state, w_next;
  logic        r_gnt_b, r_prio_b;
  logic [7:0]  r_cnt;
  logic        r_a_done, r_b_done, r_timeout;
  logic [7:0]  r_vga_cmd, r_vga_port;
  logic [10:0] r_vga_cur_adr;
  logic        r_vga_cs_h, r_vga_rl_wh;

  vga_req_t    w_a_in, w_b_in, w_a_req, w_b_req;
  logic        w_a_ready, w_b_ready, w_pick_b;
  logic        w_issue, w_fin, w_to;
  logic        w_clr_a, w_clr_b, w_load_a, w_load_b;
  logic [7:0]  w_rd_data;

  assign w_a_in = '{cmd: i_a_cmd, cur_adr: i_a_cur_adr, port: i_a_port, rl_wh: i_a_rl_wh};
  assign w_b_in = '{cmd: i_b_cmd, cur_adr: i_b_cur_adr, port: i_b_port, rl_wh: i_b_rl_wh};

  vga_req_slot u_slot_a (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_cs_h    (i_a_cs_h),
    .i_req     (w_a_in),
    .i_clr     (w_clr_a),
    .i_rd_load (w_load_a),
    .i_rd_data (w_rd_data),
    .o_ready_h (w_a_ready),
    .o_req     (w_a_req),
    .o_rd_data (o_a_port)
  );

  vga_req_slot u_slot_b (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_cs_h    (i_b_cs_h),
    .i_req     (w_b_in),
    .i_clr     (w_clr_b),
    .i_rd_load (w_load_b),
    .i_rd_data (w_rd_data),
    .o_ready_h (w_b_ready),
    .o_req     (w_b_req),
    .o_rd_data (o_b_port)
  );

  assign w_pick_b = pick_b(!w_a_ready, !w_b_ready, r_prio_b);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_fin   = 1'b0;
    w_to    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_a_ready || !w_b_ready) begin
          w_next  = ST_ISSUE;
          w_issue = 1'b1;
        end
      end
      ST_ISSUE:  w_next = ST_HOLD;
      ST_HOLD:   w_next = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (i_vga_ready_h) begin
          w_next = ST_DONE;
          w_fin  = 1'b1;
        end else if (r_cnt == TO_LAST) begin
          w_next = ST_DONE;
          w_fin  = 1'b1;
          w_to   = 1'b1;
        end
      end
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Completion side effects are computed on the WAIT_RDY->DONE edge so that
  // done, read data and the timeout flag are all registered into the DONE cycle.
  assign w_rd_data = w_to ? VGA_TIMEOUT_DATA : i_vga_port;
  assign w_load_a  = w_fin && !r_gnt_b && !w_a_req.rl_wh;
  assign w_load_b  = w_fin &&  r_gnt_b && !w_b_req.rl_wh;
  assign w_clr_a   = (r_state == ST_DONE) && !r_gnt_b;
  assign w_clr_b   = (r_state == ST_DONE) &&  r_gnt_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt_b       <= 1'b0;
      r_prio_b      <= 1'b0;
      r_cnt         <= '0;
      r_a_done      <= 1'b0;
      r_b_done      <= 1'b0;
      r_timeout     <= 1'b0;
      r_vga_cmd     <= '0;
      r_vga_cur_adr <= '0;
      r_vga_port    <= '0;
      r_vga_cs_h    <= 1'b0;
      r_vga_rl_wh   <= 1'b0;
    end else begin
      r_vga_cs_h <= w_issue;
      if (w_issue) begin
        r_gnt_b       <= w_pick_b;
        r_vga_cmd     <= w_pick_b ? w_b_req.cmd     : w_a_req.cmd;
        r_vga_cur_adr <= w_pick_b ? w_b_req.cur_adr : w_a_req.cur_adr;
        r_vga_port    <= w_pick_b ? w_b_req.port    : w_a_req.port;
        r_vga_rl_wh   <= w_pick_b ? w_b_req.rl_wh   : w_a_req.rl_wh;
      end
      r_a_done <= w_fin && !r_gnt_b;
      r_b_done <= w_fin &&  r_gnt_b;
      if (w_to) r_timeout <= 1'b1;
      if (r_state == ST_HOLD) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT_RDY && r_cnt != '1) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == ST_DONE) r_prio_b <= !r_gnt_b;
    end
  end

  assign o_a_ready_h   = w_a_ready;
  assign o_b_ready_h   = w_b_ready;
  assign o_a_done      = r_a_done;
  assign o_b_done      = r_b_done;
  assign o_vga_cmd     = r_vga_cmd;
  assign o_vga_cur_adr = r_vga_cur_adr;
  assign o_vga_port    = r_vga_port;
  assign o_vga_cs_h    = r_vga_cs_h;
  assign o_vga_rl_wh   = r_vga_rl_wh;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_vga_port_arb.sv
// Directed bench for vga_port_arb: write/read latency, busy drop, reset
// mid-transaction, round-robin ordering and timeout.
module tb_vga_port_arb;
  import vga_pkg::*;

  localparam int unsigned TO_CYC = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a_cmd = '0, b_cmd = '0, a_port = '0, b_port = '0;
  logic [10:0] a_adr = '0, b_adr = '0;
  logic        a_wh = 1'b0, b_wh = 1'b0, a_cs = 1'b0, b_cs = 1'b0;
  logic        a_rdy, b_rdy, a_done, b_done;
  logic [7:0]  a_pout, b_pout;
  logic [7:0]  vga_cmd, vga_port;
  logic [10:0] vga_adr;
  logic        vga_cs, vga_wh, vga_timeout;
  logic        vga_rdy = 1'b1;
  logic [7:0]  vga_rdata = '0;

  int n_total = 0;
  int n_bad   = 0;

  vga_port_arb #(.TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_a_cmd       (a_cmd),
    .i_a_cur_adr   (a_adr),
    .i_a_port      (a_port),
    .i_a_rl_wh     (a_wh),
    .i_a_cs_h      (a_cs),
    .i_b_cmd       (b_cmd),
    .i_b_cur_adr   (b_adr),
    .i_b_port      (b_port),
    .i_b_rl_wh     (b_wh),
    .i_b_cs_h      (b_cs),
    .o_a_ready_h   (a_rdy),
    .o_b_ready_h   (b_rdy),
    .o_a_port      (a_pout),
    .o_b_port      (b_pout),
    .o_a_done      (a_done),
    .o_b_done      (b_done),
    .o_vga_cmd     (vga_cmd),
    .o_vga_cur_adr (vga_adr),
    .o_vga_port    (vga_port),
    .o_vga_cs_h    (vga_cs),
    .o_vga_rl_wh   (vga_wh),
    .i_vga_ready_h (vga_rdy),
    .i_vga_port    (vga_rdata),
    .o_timeout     (vga_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [7:0] c, input logic [10:0] ad, input logic [7:0] p, input logic w);
    a_cmd = c; a_adr = ad; a_port = p; a_wh = w;
  endtask

  task automatic set_b(input logic [7:0] c, input logic [10:0] ad, input logic [7:0] p, input logic w);
    b_cmd = c; b_adr = ad; b_port = p; b_wh = w;
  endtask

  // Strobe is sampled at the next posedge; returns 1ns after it.
  task automatic pulse(input logic sa, input logic sb);
    a_cs = sa; b_cs = sb;
    tick(1);
    a_cs = 1'b0; b_cs = 1'b0;
  endtask

  initial begin
    int ncs, nda, ndb, nseq;
    logic [7:0] seq [0:3];

    // Reset values
    tick(3);
    chk("rst_a_ready", a_rdy, 1);
    chk("rst_b_ready", b_rdy, 1);
    chk("rst_cs", vga_cs, 0);
    chk("rst_done", {a_done, b_done}, 0);
    chk("rst_timeout", vga_timeout, 0);
    chk("rst_vga_cmd", vga_cmd, 0);
    chk("rst_a_port", a_pout, 0);
    rst_n = 1'b1;
    tick(2);

    // Write from A: cs 2 cycles after strobe, done 5 cycles after
    set_a(VGA_CMD_H81, 11'h123, 8'h41, 1'b1);
    pulse(1'b1, 1'b0);
    chk("wr_ready_low", a_rdy, 0);
    tick(1);
    chk("wr_cs", vga_cs, 1);
    chk("wr_vga_port", vga_port, 8'h41);
    chk("wr_vga_cmd", vga_cmd, 8'h81);
    chk("wr_vga_adr", vga_adr, 11'h123);
    chk("wr_vga_wh", vga_wh, 1);
    tick(1);
    chk("wr_hold_cs", vga_cs, 0);
    chk("wr_hold_wh", vga_wh, 1);
    tick(1);
    chk("wr_no_early_done", a_done, 0);
    tick(1);
    chk("wr_done", a_done, 1);
    chk("wr_done_ready_low", a_rdy, 0);
    // Strobe during DONE must be dropped
    set_a(VGA_CMD_H02, 11'h0, 8'hEE, 1'b1);
    pulse(1'b1, 1'b0);
    chk("wr_done_pulse_one", a_done, 0);
    chk("wr_ready_back", a_rdy, 1);
    tick(3);
    chk("done_strobe_dropped", vga_port, 8'h41);
    chk("done_strobe_ready", a_rdy, 1);
    chk("wr_a_port_kept", a_pout, 0);

    // Read from A
    vga_rdata = 8'h5A;
    set_a(VGA_CMD_H00, 11'h7FF, 8'h00, 1'b0);
    pulse(1'b1, 1'b0);
    tick(4);
    chk("rd_done", a_done, 1);
    chk("rd_a_port", a_pout, 8'h5A);
    chk("rd_vga_wh", vga_wh, 0);
    chk("rd_vga_cmd", vga_cmd, 8'h00);
    tick(1);
    chk("rd_done_clear", a_done, 0);
    chk("rd_a_port_hold", a_pout, 8'h5A);

    // Busy drop: second A strobe while slot full
    set_a(VGA_CMD_H02, 11'h5, 8'h77, 1'b1);
    pulse(1'b1, 1'b0);
    set_a(VGA_CMD_H03, 11'h6, 8'h99, 1'b1);
    pulse(1'b1, 1'b0);
    ncs = int'(vga_cs);
    nda = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      ncs += int'(vga_cs);
      nda += int'(a_done);
    end
    chk("busy_cs_count", ncs, 1);
    chk("busy_done_count", nda, 1);
    chk("busy_vga_port", vga_port, 8'h77);
    chk("busy_vga_cmd", vga_cmd, 8'h02);

    // Reset in WAIT_RDY
    vga_rdy = 1'b0;
    set_a(VGA_CMD_H04, 11'h44, 8'h00, 1'b0);
    pulse(1'b1, 1'b0);
    tick(3);
    chk("mid_wait_cs", vga_cs, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_ready", a_rdy, 1);
    chk("mid_rst_b_ready", b_rdy, 1);
    chk("mid_rst_a_port", a_pout, 0);
    chk("mid_rst_vga_cmd", vga_cmd, 0);
    chk("mid_rst_vga_adr", vga_adr, 0);
    chk("mid_rst_vga_port", vga_port, 0);
    chk("mid_rst_vga_wh", vga_wh, 0);
    chk("mid_rst_done", {a_done, b_done}, 0);
    tick(2);
    rst_n = 1'b1;
    vga_rdy = 1'b1;
    ncs = 0;
    nda = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      ncs += int'(vga_cs);
      nda += int'(a_done);
    end
    chk("mid_no_cs", ncs, 0);
    chk("mid_no_done", nda, 0);

    // Simultaneous strobes after reset: A first, then B
    set_a(VGA_CMD_H82, 11'h10, 8'hA1, 1'b1);
    set_b(VGA_CMD_H84, 11'h20, 8'hB1, 1'b1);
    pulse(1'b1, 1'b1);
    chk("pair1_a_latched", a_rdy, 0);
    chk("pair1_b_latched", b_rdy, 0);
    nseq = 0; nda = 0; ndb = 0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (vga_cs === 1'b1 && nseq < 4) begin
        seq[nseq] = vga_port;
        nseq++;
      end
      nda += int'(a_done);
      ndb += int'(b_done);
    end
    chk("pair1_issues", nseq, 2);
    chk("pair1_first", seq[0], 8'hA1);
    chk("pair1_second", seq[1], 8'hB1);
    chk("pair1_a_dones", nda, 1);
    chk("pair1_b_dones", ndb, 1);

    // A alone, then a tie: B must win this time
    set_a(VGA_CMD_H85, 11'h30, 8'hA2, 1'b1);
    pulse(1'b1, 1'b0);
    tick(4);
    chk("solo_a_done", a_done, 1);
    chk("solo_a_port", vga_port, 8'hA2);
    tick(1);
    vga_rdata = 8'hC3;
    set_a(VGA_CMD_H80, 11'h40, 8'hA3, 1'b1);
    set_b(VGA_CMD_H00, 11'h50, 8'hB3, 1'b0);
    pulse(1'b1, 1'b1);
    nseq = 0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (vga_cs === 1'b1 && nseq < 4) begin
        seq[nseq] = vga_port;
        nseq++;
      end
    end
    chk("pair2_issues", nseq, 2);
    chk("pair2_first", seq[0], 8'hB3);
    chk("pair2_second", seq[1], 8'hA3);
    chk("pair2_b_rdata", b_pout, 8'hC3);
    chk("pair2_a_port_kept", a_pout, 8'h00);

    // Timeout on a read with ready held low
    vga_rdy = 1'b0;
    set_a(VGA_CMD_H04, 11'h60, 8'h00, 1'b0);
    pulse(1'b1, 1'b0);
    tick(TO_CYC + 2);
    chk("to_no_early_done", a_done, 0);
    chk("to_not_yet", vga_timeout, 0);
    tick(1);
    chk("to_done", a_done, 1);
    chk("to_a_port", a_pout, 8'hFF);
    chk("to_flag", vga_timeout, 1);
    vga_rdy = 1'b1;
    tick(3);
    chk("to_sticky", vga_timeout, 1);
    chk("to_ready_back", a_rdy, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
